wakeup_pipe: RTL

WAKEUP_PIPE -- requirements
Module: wakeup_pipe

---
 rtl/wakeup_pipe.sv | 139 +++++++++++++
 1 files changed

// File: rtl/wakeup_pipe.sv
// Wakeup delay pipeline: per-port latency-delayed tag broadcast and issue-queue source ready bits.
// Optional macro WAKEUP_ALLOC_BYPASS_EN ORs same-cycle broadcast matches into allocated ready bits.
module wakeup_pipe #(
   parameter int unsigned ISSUE_NUM = 4,
   parameter int unsigned PRF_WIDTH = 6,
   parameter int unsigned CIQ_DEPTH = 16,
   parameter int unsigned MAX_LAT   = 4,
   parameter int unsigned LAT_W     = $clog2(MAX_LAT + 1)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush,
   input  logic [ISSUE_NUM-1:0]           arbit_grant,
   input  logic [ISSUE_NUM-1:0]           arbit_prd_v,
   input  logic [ISSUE_NUM*PRF_WIDTH-1:0] arbit_prd,
   input  logic [ISSUE_NUM*LAT_W-1:0]     arbit_lat,
   input  logic [CIQ_DEPTH*PRF_WIDTH-1:0] ciq_prs1,
   input  logic [CIQ_DEPTH*PRF_WIDTH-1:0] ciq_prs2,
   input  logic [CIQ_DEPTH-1:0]           alloc_we,
   input  logic [CIQ_DEPTH-1:0]           alloc_rdy1,
   input  logic [CIQ_DEPTH-1:0]           alloc_rdy2,
   output logic [CIQ_DEPTH-1:0]           prs1_rdy,
   output logic [CIQ_DEPTH-1:0]           prs2_rdy,
   output logic [ISSUE_NUM-1:0]           wake_v,
   output logic [ISSUE_NUM*PRF_WIDTH-1:0] wake_tag,
   output logic                           wake_conflict
);

   // MAX_LAT == 1 keeps one dummy stage that is never written.
   localparam int unsigned STG = (MAX_LAT > 1) ? MAX_LAT - 1 : 1;

   logic [ISSUE_NUM-1:0][STG-1:0]                stg_v_q, stg_v_d;
   logic [ISSUE_NUM-1:0][STG-1:0][PRF_WIDTH-1:0] stg_tag_q, stg_tag_d;
   logic                                         conflict_q, conflict_d;
   logic [CIQ_DEPTH-1:0]                         rdy1_q, rdy1_d, rdy2_q, rdy2_d;
   logic [CIQ_DEPTH-1:0]                         match1, match2;
   logic [CIQ_DEPTH-1:0]                         alloc_src1, alloc_src2;

   always_comb begin
      int unsigned lat;
      logic        qg;
      lat        = 1;
      qg         = 1'b0;
      stg_v_d    = '0;
      stg_tag_d  = stg_tag_q;
      wake_v     = '0;
      wake_tag   = '0;
      conflict_d = conflict_q;
      for (int p = 0; p < ISSUE_NUM; p++) begin
         lat = 32'(arbit_lat[p*LAT_W +: LAT_W]);
         if (lat == 0) lat = 1;
         else if (lat > MAX_LAT) lat = MAX_LAT;
         qg = arbit_grant[p] & arbit_prd_v[p];
         for (int s = 0; s < STG - 1; s++) begin
            stg_v_d[p][s]   = stg_v_q[p][s+1];
            stg_tag_d[p][s] = stg_tag_q[p][s+1];
         end
         if (stg_v_q[p][0]) begin
            wake_v[p]                          = 1'b1;
            wake_tag[p*PRF_WIDTH +: PRF_WIDTH] = stg_tag_q[p][0];
         end
         // On any collision the older (already queued) tag wins.
         if (qg && lat == 1) begin
            if (stg_v_q[p][0]) begin
               conflict_d = 1'b1;
            end else begin
               wake_v[p]                          = 1'b1;
               wake_tag[p*PRF_WIDTH +: PRF_WIDTH] = arbit_prd[p*PRF_WIDTH +: PRF_WIDTH];
            end
         end else if (qg) begin
            for (int s = 0; s < STG; s++) begin
               if (s + 2 == lat) begin
                  if (stg_v_d[p][s]) begin
                     conflict_d = 1'b1;
                  end else begin
                     stg_v_d[p][s]   = 1'b1;
                     stg_tag_d[p][s] = arbit_prd[p*PRF_WIDTH +: PRF_WIDTH];
                  end
               end
            end
         end
      end
      if (flush) begin
         stg_v_d    = '0;
         conflict_d = conflict_q;
      end
   end

   always_comb begin
      match1 = '0;
      match2 = '0;
      for (int i = 0; i < CIQ_DEPTH; i++) begin
         for (int p = 0; p < ISSUE_NUM; p++) begin
            if (wake_v[p] && wake_tag[p*PRF_WIDTH +: PRF_WIDTH] == ciq_prs1[i*PRF_WIDTH +: PRF_WIDTH])
               match1[i] = 1'b1;
            if (wake_v[p] && wake_tag[p*PRF_WIDTH +: PRF_WIDTH] == ciq_prs2[i*PRF_WIDTH +: PRF_WIDTH])
               match2[i] = 1'b1;
         end
      end
   end

`ifdef WAKEUP_ALLOC_BYPASS_EN
   assign alloc_src1 = alloc_rdy1 | match1;
   assign alloc_src2 = alloc_rdy2 | match2;
`else
   assign alloc_src1 = alloc_rdy1;
   assign alloc_src2 = alloc_rdy2;
`endif

   always_comb begin
      rdy1_d = (alloc_we & alloc_src1) | (~alloc_we & (rdy1_q | match1));
      rdy2_d = (alloc_we & alloc_src2) | (~alloc_we & (rdy2_q | match2));
      if (flush) begin
         rdy1_d = '0;
         rdy2_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stg_v_q    <= '0;
         stg_tag_q  <= '0;
         conflict_q <= 1'b0;
         rdy1_q     <= '0;
         rdy2_q     <= '0;
      end else begin
         stg_v_q    <= stg_v_d;
         stg_tag_q  <= stg_tag_d;
         conflict_q <= conflict_d;
         rdy1_q     <= rdy1_d;
         rdy2_q     <= rdy2_d;
      end
   end

   assign prs1_rdy      = rdy1_q;
   assign prs2_rdy      = rdy2_q;
   assign wake_conflict = conflict_q;

endmodule
